// File: rtl/nested_fsm_pkg.sv
// Shared definitions for nested_fsm_ctrl: state encoding, command codes,
// out codes and small state helpers.
package nested_fsm_pkg;

    typedef enum logic [2:0] {
        ST_BLUE     = 3'd0,
        ST_RED      = 3'd1,
        ST_HSV_IDLE = 3'd2,
        ST_HSV_HUE  = 3'd3,
        ST_HSV_SAT  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_GO_RED    = 2'd0;
    localparam logic [1:0] CMD_TOGGLE    = 2'd1;
    localparam logic [1:0] CMD_ENTER_HSV = 2'd2;
    localparam logic [1:0] CMD_STEP      = 2'd3;

    localparam logic [1:0] OUT_BLUE     = 2'd1;
    localparam logic [1:0] OUT_RED      = 2'd2;
    localparam logic [1:0] OUT_HSV_IDLE = 2'd2;
    localparam logic [1:0] OUT_HSV_HUE  = 2'd3;
    localparam logic [1:0] OUT_HSV_SAT  = 2'd0;

    function automatic logic is_hsv(input state_t s);
        return (s == ST_HSV_IDLE) || (s == ST_HSV_HUE) || (s == ST_HSV_SAT);
    endfunction

    // IDLE -> HUE -> SAT -> IDLE; anything unexpected lands back on IDLE.
    function automatic state_t hsv_advance(input state_t s);
        state_t n;
        case (s)
            ST_HSV_IDLE: n = ST_HSV_HUE;
            ST_HSV_HUE:  n = ST_HSV_SAT;
            default:     n = ST_HSV_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/nested_fsm_ctrl_idle_timer.sv
// fsm_idle_timer: idle-cycle counter used by nested_fsm_ctrl when the
// forced-return feature (NESTED_FSM_TIMEOUT_EN) is compiled in.
// expired is high while the count sits at TIMEOUT-1; the count saturates
// there, so it can never wrap even if the owner ignores expired.
module fsm_idle_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count idle cycles; clear wins over enable, and the count stops at LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/nested_fsm_ctrl.sv
// nested_fsm_ctrl: colour-mode controller with a nested HSV sub-sequence.
// Optional forced return to RED after TIMEOUT idle cycles outside RED is
// compiled in with the macro NESTED_FSM_TIMEOUT_EN.
//
// state       | meaning
// ------------+----------------------------------------------
// ST_BLUE     | blue mode, only TOGGLE leaves
// ST_RED      | home state after reset or forced return
// ST_HSV_IDLE | HSV sub-sequence, first step
// ST_HSV_HUE  | HSV sub-sequence, hue step
// ST_HSV_SAT  | HSV sub-sequence, saturation step (wraps to IDLE)
module nested_fsm_ctrl
    import nested_fsm_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             in_hsv,
    output logic             changed,
    output logic             timeout
);

    state_t     state;
    state_t     state_next;
    logic [1:0] cmd;
    logic [1:0] out_code;
    logic       forced;
    logic       unused_in_bits;

    assign cmd = in[1:0];
    // Upper command bits carry no meaning; fold them so they are consumed.
    assign unused_in_bits = ^in;

`ifdef NESTED_FSM_TIMEOUT_EN
    logic expired;
    logic timer_clear;
    logic timer_enable;

    assign timer_clear  = (state_next != state) || (state == ST_RED);
    assign timer_enable = (state != ST_RED);

    fsm_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (expired)
    );

    assign forced = expired && (state != ST_RED);
`else
    localparam int unused_timeout = TIMEOUT;

    assign forced = 1'b0;
`endif

    // Next-state selection; a forced return overrides and drops any command.
    always_comb begin
        state_next = state;
        if (forced) begin
            state_next = ST_RED;
        end else if (in_valid) begin
            case (state)
                ST_BLUE: begin
                    if (cmd == CMD_TOGGLE) state_next = ST_RED;
                end
                ST_RED: begin
                    case (cmd)
                        CMD_TOGGLE:    state_next = ST_BLUE;
                        CMD_ENTER_HSV: state_next = ST_HSV_IDLE;
                        default:       state_next = state;
                    endcase
                end
                ST_HSV_IDLE, ST_HSV_HUE, ST_HSV_SAT: begin
                    case (cmd)
                        CMD_STEP:   state_next = hsv_advance(state);
                        CMD_GO_RED: state_next = ST_RED;
                        default:    state_next = state;
                    endcase
                end
                default: state_next = ST_RED;
            endcase
        end
    end

    // State register plus registered change and forced-return pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RED;
            changed <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            changed <= (state_next != state);
            timeout <= forced;
        end
    end

    // Output decode of the current state, zero-extended to WIDTH.
    always_comb begin
        out_code = OUT_RED;
        case (state)
            ST_BLUE:     out_code = OUT_BLUE;
            ST_RED:      out_code = OUT_RED;
            ST_HSV_IDLE: out_code = OUT_HSV_IDLE;
            ST_HSV_HUE:  out_code = OUT_HSV_HUE;
            ST_HSV_SAT:  out_code = OUT_HSV_SAT;
            default:     out_code = OUT_RED;
        endcase
        out      = '0;
        out[1:0] = out_code;
        in_hsv   = is_hsv(state);
    end

endmodule

// File: tb/tb_nested_fsm_ctrl.sv
// Self-checking bench for nested_fsm_ctrl (WIDTH=4, TIMEOUT=15).
// Works with or without NESTED_FSM_TIMEOUT_EN defined.
module tb_nested_fsm_ctrl;

    localparam int W  = 4;
    localparam int TO = 15;

`ifdef NESTED_FSM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in;
    logic [W-1:0] out;
    logic         in_hsv;
    logic         changed;
    logic         timeout;

    nested_fsm_ctrl #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in       (in),
        .out      (out),
        .in_hsv   (in_hsv),
        .changed  (changed),
        .timeout  (timeout)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] d;
        logic [3:0] o;
        logic       h;
        logic       c;
        logic       t;
    } row_t;

    row_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(input logic v, input logic [3:0] d, input logic [3:0] o,
                                input logic h, input logic c, input logic t);
        return {v, d, o, h, c, t};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, land 1 ns past the edge.
    task automatic drive(input row_t r);
        @(negedge clk);
        in_valid = r.v;
        in       = r.d;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        in       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        row_t e;
        in_valid = 1'b0;
        in       = '0;
        rst      = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out !== 4'h2 || in_hsv !== 1'b0 || changed !== 1'b0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: out=%h hsv=%b chg=%b tmo=%b, expected 2 0 0 0",
                     out, in_hsv, changed, timeout);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out !== 4'h2 || in_hsv !== 1'b0 || changed !== 1'b0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: out=%h hsv=%b chg=%b tmo=%b, expected 2 0 0 0",
                     out, in_hsv, changed, timeout);
        end
        // first command is presented in the same cycle reset is released
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in       = 4'h1;
        exp_q.push_back(mk(1'b1, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (out !== e.o || in_hsv !== e.h || changed !== e.c || timeout !== e.t) begin
            n_bad++;
            $display("FAIL reset_first_cmd: out=%h hsv=%b chg=%b tmo=%b, expected %h %b %b %b",
                     out, in_hsv, changed, timeout, e.o, e.h, e.c, e.t);
        end
    endtask

    task automatic test_toggle();
        row_t rows[$];
        row_t e;
        do_reset();
        n_cmp++;
        if (out !== 4'h2 || changed !== 1'b0) begin
            n_bad++;
            $display("FAIL toggle_start: out=%h chg=%b, expected 2 0", out, changed);
        end
        rows.push_back(mk(1, 4'h1, 4'h1, 0, 1, 0));
        rows.push_back(mk(1, 4'h1, 4'h2, 0, 1, 0));
        rows.push_back(mk(0, 4'h1, 4'h2, 0, 0, 0));
        rows.push_back(mk(1, 4'h0, 4'h2, 0, 0, 0));
        rows.push_back(mk(1, 4'h3, 4'h2, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e.o || in_hsv !== e.h || changed !== e.c || timeout !== e.t) begin
                n_bad++;
                $display("FAIL toggle[%0d]: out=%h hsv=%b chg=%b tmo=%b, expected %h %b %b %b",
                         i, out, in_hsv, changed, timeout, e.o, e.h, e.c, e.t);
            end
        end
    endtask

    task automatic test_hsv();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, 4'h2, 4'h2, 1, 1, 0));
        rows.push_back(mk(1, 4'h3, 4'h3, 1, 1, 0));
        rows.push_back(mk(1, 4'h3, 4'h0, 1, 1, 0));
        rows.push_back(mk(1, 4'h3, 4'h2, 1, 1, 0));
        rows.push_back(mk(1, 4'h3, 4'h3, 1, 1, 0));
        rows.push_back(mk(1, 4'h1, 4'h3, 1, 0, 0));
        rows.push_back(mk(1, 4'h2, 4'h3, 1, 0, 0));
        rows.push_back(mk(0, 4'h3, 4'h3, 1, 0, 0));
        rows.push_back(mk(1, 4'h0, 4'h2, 0, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e.o || in_hsv !== e.h || changed !== e.c || timeout !== e.t) begin
                n_bad++;
                $display("FAIL hsv[%0d]: out=%h hsv=%b chg=%b tmo=%b, expected %h %b %b %b",
                         i, out, in_hsv, changed, timeout, e.o, e.h, e.c, e.t);
            end
        end
    endtask

    task automatic test_wide_cmd();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, 4'hE, 4'h2, 1, 1, 0));
        rows.push_back(mk(1, 4'hF, 4'h3, 1, 1, 0));
        rows.push_back(mk(1, 4'hC, 4'h2, 0, 1, 0));
        rows.push_back(mk(1, 4'h4, 4'h2, 0, 0, 0));
        rows.push_back(mk(1, 4'h7, 4'h2, 0, 0, 0));
        rows.push_back(mk(1, 4'h5, 4'h1, 0, 1, 0));
        rows.push_back(mk(1, 4'hB, 4'h1, 0, 0, 0));
        rows.push_back(mk(1, 4'h6, 4'h1, 0, 0, 0));
        rows.push_back(mk(1, 4'h8, 4'h1, 0, 0, 0));
        rows.push_back(mk(1, 4'hD, 4'h2, 0, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e.o || in_hsv !== e.h || changed !== e.c || timeout !== e.t) begin
                n_bad++;
                $display("FAIL wide_cmd[%0d]: out=%h hsv=%b chg=%b tmo=%b, expected %h %b %b %b",
                         i, out, in_hsv, changed, timeout, e.o, e.h, e.c, e.t);
            end
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, 4'h1, 4'h1, 0, 1, 0));
        for (int k = 1; k < TO; k++) rows.push_back(mk(0, 4'h0, 4'h1, 0, 0, 0));
        rows.push_back(TMO_EN ? mk(0, 4'h0, 4'h2, 0, 1, 1) : mk(0, 4'h0, 4'h1, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            rows.push_back(mk(0, 4'h0, TMO_EN ? 4'h2 : 4'h1, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e.o || in_hsv !== e.h || changed !== e.c || timeout !== e.t) begin
                n_bad++;
                $display("FAIL timeout[%0d]: out=%h hsv=%b chg=%b tmo=%b, expected %h %b %b %b",
                         i, out, in_hsv, changed, timeout, e.o, e.h, e.c, e.t);
            end
        end
    endtask

    task automatic test_timeout_priority();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, 4'h2, 4'h2, 1, 1, 0));
        rows.push_back(mk(1, 4'h3, 4'h3, 1, 1, 0));
        for (int k = 1; k < TO; k++) rows.push_back(mk(0, 4'h3, 4'h3, 1, 0, 0));
        rows.push_back(TMO_EN ? mk(1, 4'h3, 4'h2, 0, 1, 1) : mk(1, 4'h3, 4'h0, 1, 1, 0));
        rows.push_back(mk(0, 4'h0, TMO_EN ? 4'h2 : 4'h0, !TMO_EN, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e.o || in_hsv !== e.h || changed !== e.c || timeout !== e.t) begin
                n_bad++;
                $display("FAIL tmo_priority[%0d]: out=%h hsv=%b chg=%b tmo=%b, expected %h %b %b %b",
                         i, out, in_hsv, changed, timeout, e.o, e.h, e.c, e.t);
            end
        end
    endtask

    task automatic test_reset_mid_hsv();
        row_t rows[$];
        row_t e;
        do_reset();
        rows.push_back(mk(1, 4'h2, 4'h2, 1, 1, 0));
        rows.push_back(mk(1, 4'h3, 4'h3, 1, 1, 0));
        rows.push_back(mk(1, 4'h3, 4'h0, 1, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e.o || in_hsv !== e.h || changed !== e.c || timeout !== e.t) begin
                n_bad++;
                $display("FAIL mid_hsv_setup[%0d]: out=%h hsv=%b chg=%b tmo=%b, expected %h %b %b %b",
                         i, out, in_hsv, changed, timeout, e.o, e.h, e.c, e.t);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out !== 4'h2 || in_hsv !== 1'b0 || changed !== 1'b0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_hsv_async_rst: out=%h hsv=%b chg=%b tmo=%b, expected 2 0 0 0",
                     out, in_hsv, changed, timeout);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        rows.delete();
        rows.push_back(mk(0, 4'h3, 4'h2, 0, 0, 0));
        rows.push_back(mk(0, 4'h3, 4'h2, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e.o || in_hsv !== e.h || changed !== e.c || timeout !== e.t) begin
                n_bad++;
                $display("FAIL mid_hsv_release[%0d]: out=%h hsv=%b chg=%b tmo=%b, expected %h %b %b %b",
                         i, out, in_hsv, changed, timeout, e.o, e.h, e.c, e.t);
            end
        end
    endtask

    // Random traffic checked against a behavioural model.
    // Model states: 0 BLUE, 1 RED, 2 HSV_IDLE, 3 HSV_HUE, 4 HSV_SAT.
    task automatic test_random();
        int         ms;
        int         mc;
        int         nxt;
        logic       v;
        logic [3:0] d;
        logic       frc;
        logic       chg;
        logic [3:0] o;
        row_t       e;
        do_reset();
        ms = 1;
        mc = 0;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) == 0);
            d   = 4'($urandom_range(0, 15));
            frc = TMO_EN && (ms != 1) && (mc == TO - 1);
            nxt = ms;
            if (frc) nxt = 1;
            else if (v) begin
                if (ms == 0) begin
                    if (d[1:0] == 2'd1) nxt = 1;
                end else if (ms == 1) begin
                    if (d[1:0] == 2'd1) nxt = 0;
                    else if (d[1:0] == 2'd2) nxt = 2;
                end else begin
                    if (d[1:0] == 2'd3) nxt = (ms == 4) ? 2 : ms + 1;
                    else if (d[1:0] == 2'd0) nxt = 1;
                end
            end
            chg = (nxt != ms);
            mc  = (chg || ms == 1) ? 0 : mc + 1;
            ms  = nxt;
            case (ms)
                0:       o = 4'h1;
                1:       o = 4'h2;
                2:       o = 4'h2;
                3:       o = 4'h3;
                default: o = 4'h0;
            endcase
            drive(mk(v, d, o, ms >= 2, chg, frc));
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e.o || in_hsv !== e.h || changed !== e.c || timeout !== e.t) begin
                n_bad++;
                $display("FAIL random[%0d]: out=%h hsv=%b chg=%b tmo=%b, expected %h %b %b %b",
                         n, out, in_hsv, changed, timeout, e.o, e.h, e.c, e.t);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in       = '0;
        test_reset();
        test_toggle();
        test_hsv();
        test_wide_cmd();
        test_timeout();
        test_timeout_priority();
        test_reset_mid_hsv();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nested_fsm_ctrl.md
NESTED_FSM_CTRL -- requirements
Module: nested_fsm_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port SHALL be named clk and the reset port rst.
REQ-002 The block SHALL have parameter WIDTH, default 2: data width of in and out; legal values are >= 2.
REQ-003 The block SHALL have parameter TIMEOUT, default 15: number of idle cycles allowed outside RED before a forced return; legal values are >= 2.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the command on in is sampled only when in_valid is high.
REQ-007 The block SHALL have port in, input, WIDTH bits: in[1:0] is the command code and in[WIDTH-1:2] is ignored.
REQ-008 The block SHALL have port out, output, WIDTH bits: state output code, zero-extended.
REQ-009 The block SHALL have port in_hsv, output, 1 bit: high while in any HSV_* state.
REQ-010 The block SHALL have port changed, output, 1 bit: one-cycle pulse in the first cycle a new state is held.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse in the first cycle after a forced return to RED.

Function
REQ-012 The block SHALL implement the states BLUE, RED, HSV_IDLE, HSV_HUE and HSV_SAT, held in a single state register.
REQ-013 The command codes SHALL be: 0 = GO_RED, 1 = TOGGLE, 2 = ENTER_HSV, 3 = STEP.
REQ-014 In BLUE, TOGGLE SHALL go to RED; all other commands hold the state.
REQ-015 In RED, TOGGLE SHALL go to BLUE, ENTER_HSV SHALL go to HSV_IDLE, and GO_RED or STEP SHALL hold the state.
REQ-016 In the HSV_* states, STEP SHALL advance IDLE->HUE->SAT->IDLE (wrapping), GO_RED SHALL go to RED, and TOGGLE or ENTER_HSV SHALL hold the state.
REQ-017 When in_valid is low, the state SHALL hold, subject to REQ-020.
REQ-018 Transition latency SHALL be one cycle: a command sampled at edge N is reflected in the state after edge N.
REQ-019 out SHALL be a combinational decode of the current state: BLUE = 1, RED = 2, HSV_IDLE = 2, HSV_HUE = 3, HSV_SAT = 0.
REQ-020 The idle counter SHALL clear on any state change and while in RED, and SHALL otherwise increment each cycle; when it equals TIMEOUT-1, the next state SHALL be forced to RED.
REQ-021 When the timeout condition and a valid command occur in the same cycle, the timeout SHALL take priority and the command SHALL be dropped.
REQ-022 The idle counter width SHALL be $clog2(TIMEOUT) bits and the counter SHALL never wrap.
REQ-023 changed SHALL be registered: high exactly when the state differs from its value in the previous cycle.
REQ-024 timeout SHALL be registered: high for exactly one cycle after each forced return.
REQ-025 A hold that is a self-transition (for example GO_RED while in RED) SHALL NOT assert changed.

Reset
REQ-026 When rst is asserted, and asynchronously without waiting for a clock edge, the state SHALL be RED, the idle counter 0, changed 0 and timeout 0.
REQ-027 While rst is high, out SHALL be 2 and in_hsv SHALL be 0.
REQ-028 Assertion of rst mid-HSV sequence SHALL abandon the sequence with no changed pulse on release.
REQ-029 The first valid command after reset release SHALL be acted on at the first clock edge.

Configuration
REQ-030 The macro NESTED_FSM_TIMEOUT_EN SHALL compile the timeout feature in or out.
REQ-031 With NESTED_FSM_TIMEOUT_EN defined, the idle counter, forced return and timeout output SHALL be present as specified.
REQ-032 Without NESTED_FSM_TIMEOUT_EN, no counter SHALL be instantiated, timeout SHALL be tied to 0 and states SHALL change only on commands.

Structure
REQ-033 The state enum, the command-code localparams and the out codes SHALL reside in the shared package nested_fsm_pkg.
REQ-034 The idle counter SHALL be the sub-module fsm_idle_timer, with inputs clk, rst, clear and enable, output expired, and parameter TIMEOUT.
REQ-035 The next-state logic and the output decode SHALL be separate combinational processes in the top module, each with a default branch.

Verification
REQ-036 Reset release, then TOGGLE, TOGGLE -> state BLUE then RED; out sequence 2, 1, 2; changed pulses twice.
REQ-037 ENTER_HSV, then STEP x4 -> IDLE, HUE, SAT, IDLE, HUE; out sequence 2, 3, 0, 2, 3; in_hsv = 1 throughout.
REQ-038 With WIDTH=4 and in=4'hE (command ENTER_HSV) from RED -> HSV_IDLE; out = 4'h2.
REQ-039 With TIMEOUT_EN defined and TIMEOUT=15, enter BLUE then hold in_valid low -> RED after 15 cycles; timeout pulses once with changed high in the same cycle.
REQ-040 Timeout cycle coincident with a valid STEP while in HSV_HUE -> RED, not HSV_SAT.
REQ-041 Assert rst while in HSV_SAT -> out = 2 immediately, before any clock edge.
